sevseg_capture: RTL and testbench

SEVSEG_CAPTURE -- requirements
Module: sevseg_capture

---
 rtl/sevseg_capture.sv | 184 ++++++++++++++++++
 tb/tb_sevseg_capture.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevseg_capture.sv
// Captures a multiplexed 7-segment display bus into four hex nibbles with frame and timeout detection.
// Optional macro SEVSEG_CAPTURE_ACTIVE_LOW_EN inverts anode/seg at the input for common-anode boards.
module sevseg_capture #(
  parameter int unsigned STABLE_CNT = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  anode,
  input  logic [6:0]  seg,
  input  logic        sample_en,
  output logic [15:0] digits,
  output logic [3:0]  digit_err,
  output logic        anode_err,
  output logic        frame_valid,
  output logic        timeout,
  output logic [1:0]  fsm_state   // debug: 0=IDLE 1=GOT0 2=GOT1 3=GOT2
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GOT0 = 2'd1,
    GOT1 = 2'd2,
    GOT2 = 2'd3
  } state_e;

  localparam logic [3:0]  RUN_MAX = 4'(STABLE_CNT);
  localparam logic [15:0] TO_MAX  = 16'(TIMEOUT);

  logic [3:0]  anode_i;
  logic [6:0]  seg_i;

`ifdef SEVSEG_CAPTURE_ACTIVE_LOW_EN
  assign anode_i = ~anode;
  assign seg_i   = ~seg;
`else
  assign anode_i = anode;
  assign seg_i   = seg;
`endif

  state_e      state_q, state_d;
  logic [3:0]  prev_anode_q, prev_anode_d;
  logic [6:0]  prev_seg_q, prev_seg_d;
  logic [3:0]  run_q, run_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  digit_err_q, digit_err_d;
  logic        anode_err_q, anode_err_d;
  logic        frame_valid_q, frame_valid_d;
  logic        timeout_q, timeout_d;

  logic        onehot;
  logic        same;
  logic        do_latch;
  logic        dec_ok;
  logic [3:0]  dec_val;

  assign onehot = (anode_i != 4'd0) && ((anode_i & (anode_i - 4'd1)) == 4'd0);
  assign same   = (anode_i == prev_anode_q) && (seg_i == prev_seg_q);

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'h0;
    case (seg_i)
      7'h3F: dec_val = 4'h0;
      7'h06: dec_val = 4'h1;
      7'h5B: dec_val = 4'h2;
      7'h4F: dec_val = 4'h3;
      7'h66: dec_val = 4'h4;
      7'h6D: dec_val = 4'h5;
      7'h7D: dec_val = 4'h6;
      7'h07: dec_val = 4'h7;
      7'h7F: dec_val = 4'h8;
      7'h6F: dec_val = 4'h9;
      7'h77: dec_val = 4'hA;
      7'h7C: dec_val = 4'hB;
      7'h39: dec_val = 4'hC;
      7'h5E: dec_val = 4'hD;
      7'h79: dec_val = 4'hE;
      7'h71: dec_val = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    prev_anode_d  = prev_anode_q;
    prev_seg_d    = prev_seg_q;
    run_d         = run_q;
    tcnt_d        = tcnt_q;
    digits_d      = digits_q;
    digit_err_d   = digit_err_q;
    anode_err_d   = 1'b0;
    frame_valid_d = 1'b0;
    timeout_d     = 1'b0;
    do_latch      = 1'b0;

    if (sample_en) begin
      prev_anode_d = anode_i;
      prev_seg_d   = seg_i;

      // A saturated run never re-latches; only the edge that reaches the threshold does.
      if (!onehot) begin
        anode_err_d = 1'b1;
        run_d       = 4'd0;
      end else if (same) begin
        if (run_q < RUN_MAX) begin
          run_d    = run_q + 4'd1;
          do_latch = ((run_q + 4'd1) == RUN_MAX);
        end
      end else begin
        run_d    = 4'd1;
        do_latch = (RUN_MAX == 4'd1);
      end

      if (do_latch) begin
        for (int k = 0; k < 4; k++) begin
          if (anode_i[k]) begin
            if (dec_ok) begin
              digits_d[4*k +: 4] = dec_val;
              digit_err_d[k]     = 1'b0;
            end else begin
              digit_err_d[k] = 1'b1;
            end
          end
        end

        if (anode_i[0]) begin
          state_d = GOT0;
        end else if (anode_i[1] && (state_q == GOT0)) begin
          state_d = GOT1;
        end else if (anode_i[2] && (state_q == GOT1)) begin
          state_d = GOT2;
        end else if (anode_i[3] && (state_q == GOT2)) begin
          state_d       = IDLE;
          frame_valid_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
        tcnt_d = 16'd0;
      end else if ((tcnt_q + 16'd1) == TO_MAX) begin
        state_d   = IDLE;
        timeout_d = 1'b1;
        tcnt_d    = 16'd0;
      end else begin
        tcnt_d = tcnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      prev_anode_q  <= 4'd0;
      prev_seg_q    <= 7'd0;
      run_q         <= 4'd0;
      tcnt_q        <= 16'd0;
      digits_q      <= 16'h0000;
      digit_err_q   <= 4'd0;
      anode_err_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_anode_q  <= prev_anode_d;
      prev_seg_q    <= prev_seg_d;
      run_q         <= run_d;
      tcnt_q        <= tcnt_d;
      digits_q      <= digits_d;
      digit_err_q   <= digit_err_d;
      anode_err_q   <= anode_err_d;
      frame_valid_q <= frame_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign digits      = digits_q;
  assign digit_err   = digit_err_q;
  assign anode_err   = anode_err_q;
  assign frame_valid = frame_valid_q;
  assign timeout     = timeout_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_sevseg_capture.sv
// Randomised and directed bench for sevseg_capture against a behavioural display-capture model.
module tb_sevseg_capture;

  localparam int STABLE = 2;
  localparam int TMO    = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  anode = 4'd0;
  logic [6:0]  seg = 7'd0;
  logic        sample_en = 1'b0;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        anode_err;
  logic        frame_valid;
  logic        timeout;
  logic [1:0]  fsm_state;

  always #5 clk = ~clk;

  sevseg_capture #(.STABLE_CNT(STABLE), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .anode(anode), .seg(seg), .sample_en(sample_en),
    .digits(digits), .digit_err(digit_err), .anode_err(anode_err),
    .frame_valid(frame_valid), .timeout(timeout), .fsm_state(fsm_state)
  );

  int total = 0;
  int bad   = 0;

  logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: m_got counts how many digits of the current frame are in hand.
  logic [3:0] m_prev_an;
  logic [6:0] m_prev_seg;
  int         m_run;
  logic [3:0] m_dig [4];
  logic [3:0] m_err;
  int         m_got;
  int         m_since;
  logic       e_ae, e_fv, e_to;
  int         ae_seen = 0, fv_seen = 0, to_seen = 0;

  function automatic logic [15:0] exp_digits();
    return {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
  endfunction

  task automatic model_reset();
    m_prev_an = 4'd0; m_prev_seg = 7'd0; m_run = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
    m_err = 4'd0; m_got = 0; m_since = 0;
  endtask

  task automatic model_step(input logic [3:0] an, input logic [6:0] sg);
    bit latched = 0;
    int k = 0;
    int found = -1;
    e_ae = 0; e_fv = 0; e_to = 0;
    if ($countones(an) != 1) begin
      e_ae = 1; m_run = 0;
    end else if (an == m_prev_an && sg == m_prev_seg) begin
      if (m_run < STABLE) begin
        m_run++;
        if (m_run == STABLE) latched = 1;
      end
    end else begin
      m_run = 1;
      if (STABLE == 1) latched = 1;
    end
    m_prev_an = an; m_prev_seg = sg;
    if (latched) begin
      for (int i = 0; i < 4; i++) if (an[i]) k = i;
      for (int i = 0; i < 16; i++) if (pat[i] == sg) found = i;
      if (found >= 0) begin m_dig[k] = 4'(found); m_err[k] = 1'b0; end
      else m_err[k] = 1'b1;
      if (k == 0) m_got = 1;
      else if (m_got == k) begin
        if (k == 3) begin e_fv = 1; m_got = 0; end
        else m_got = k + 1;
      end else m_got = 0;
      m_since = 0;
    end else begin
      m_since++;
      if (m_since == TMO) begin e_to = 1; m_got = 0; m_since = 0; end
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] sg);
`ifdef SEVSEG_CAPTURE_ACTIVE_LOW_EN
    anode = ~an; seg = ~sg;
`else
    anode = an; seg = sg;
`endif
  endtask

  // Driver: one strobe, then `gap` idle cycles with garbage on the bus.
  task automatic strobe(input logic [3:0] an, input logic [6:0] sg, input int gap);
    @(negedge clk);
    drive(an, sg);
    sample_en = 1'b1;
    @(posedge clk); #1;
    model_step(an, sg);
    total++;
    if ({digits, digit_err} !== {exp_digits(), m_err}) begin
      bad++;
      $display("FAIL strobe_data an=%b seg=%h got digits=%h err=%b exp digits=%h err=%b",
               an, sg, digits, digit_err, exp_digits(), m_err);
    end
    total++;
    if ({anode_err, frame_valid, timeout, fsm_state} !== {e_ae, e_fv, e_to, 2'(m_got)}) begin
      bad++;
      $display("FAIL strobe_flags an=%b seg=%h got ae/fv/to/st=%b%b%b/%0d exp %b%b%b/%0d",
               an, sg, anode_err, frame_valid, timeout, fsm_state, e_ae, e_fv, e_to, m_got);
    end
    ae_seen += int'(anode_err); fv_seen += int'(frame_valid); to_seen += int'(timeout);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      sample_en = 1'b0;
      drive(4'($urandom), 7'($urandom));
      @(posedge clk); #1;
      total++;
      if ({digits, digit_err, anode_err, frame_valid, timeout, fsm_state} !==
          {exp_digits(), m_err, 3'b000, 2'(m_got)}) begin
        bad++;
        $display("FAIL idle_hold got digits=%h err=%b pulses=%b%b%b st=%0d exp digits=%h err=%b st=%0d",
                 digits, digit_err, anode_err, frame_valid, timeout, fsm_state,
                 exp_digits(), m_err, m_got);
      end
    end
  endtask

  task automatic stable(input int k, input logic [6:0] sg);
    strobe(4'(1 << k), sg, 1);
    strobe(4'(1 << k), sg, 1);
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({digits, digit_err, anode_err, frame_valid, timeout, fsm_state} !== 27'd0) begin
      bad++;
      $display("FAIL reset_state got digits=%h err=%b pulses=%b%b%b st=%0d exp all zero",
               digits, digit_err, anode_err, frame_valid, timeout, fsm_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_frame();
    int fv0 = fv_seen;
    stable(0, 7'h06);
    stable(1, 7'h5B);
    stable(2, 7'h4F);
    strobe(4'b1000, 7'h66, 0);
    total++;
    if (frame_valid !== 1'b0) begin
      bad++; $display("FAIL frame_early got fv=%b exp 0", frame_valid);
    end
    strobe(4'b1000, 7'h66, 1);
    total++;
    if (digits !== 16'h4321 || fv_seen - fv0 != 1) begin
      bad++;
      $display("FAIL frame_result got digits=%h fv_pulses=%0d exp 4321 and 1", digits, fv_seen - fv0);
    end
  endtask

  task automatic test_digit_err();
    stable(2, 7'h00);
    total++;
    if (digit_err !== 4'b0100 || digits[11:8] !== 4'h3) begin
      bad++;
      $display("FAIL digit_err_set got err=%b d2=%h exp 0100 and 3", digit_err, digits[11:8]);
    end
    stable(2, 7'h3F);
    total++;
    if (digit_err !== 4'b0000 || digits[11:8] !== 4'h0) begin
      bad++;
      $display("FAIL digit_err_clr got err=%b d2=%h exp 0000 and 0", digit_err, digits[11:8]);
    end
  endtask

  task automatic test_anode_err();
    int ae0 = ae_seen;
    logic [15:0] d0;
    strobe(4'b0001, 7'h7F, 1);
    d0 = digits;
    strobe(4'b0011, 7'h7F, 1);
    strobe(4'b0001, 7'h7F, 1);
    total++;
    if (ae_seen - ae0 != 1 || digits !== d0) begin
      bad++;
      $display("FAIL anode_err got pulses=%0d digits=%h exp 1 and %h", ae_seen - ae0, digits, d0);
    end
    strobe(4'b0001, 7'h7F, 1);
    total++;
    if (digits[3:0] !== 4'h8) begin
      bad++; $display("FAIL anode_err_restart got d0=%h exp 8", digits[3:0]);
    end
  endtask

  task automatic test_bad_order();
    int fv0 = fv_seen;
    stable(0, pat[5]); stable(1, pat[6]); stable(3, pat[7]);
    total++;
    if (fsm_state !== 2'd0 || fv_seen != fv0) begin
      bad++; $display("FAIL bad_order got st=%0d fv=%0d exp 0 and 0", fsm_state, fv_seen - fv0);
    end
    stable(0, pat[9]); stable(1, pat[10]); stable(2, pat[11]); stable(3, pat[12]);
    total++;
    if (fv_seen - fv0 != 1 || digits !== 16'hCBA9) begin
      bad++;
      $display("FAIL good_order got fv=%0d digits=%h exp 1 and cba9", fv_seen - fv0, digits);
    end
  endtask

  task automatic test_timeout();
    int to0;
    logic [15:0] d0;
    stable(0, 7'h3F);
    to0 = to_seen;
    d0 = digits;
    for (int i = 0; i < TMO; i++) strobe(4'b0001, (i % 2 == 0) ? 7'h06 : 7'h3F, 1);
    total++;
    if (to_seen - to0 != 1 || fsm_state !== 2'd0 || digits !== d0) begin
      bad++;
      $display("FAIL timeout got pulses=%0d st=%0d digits=%h exp 1, 0, %h",
               to_seen - to0, fsm_state, digits, d0);
    end
  endtask

  task automatic test_reset_mid();
    int fv0;
    stable(0, pat[1]); stable(1, pat[2]); stable(2, pat[3]);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if ({digits, digit_err, anode_err, frame_valid, timeout, fsm_state} !== 27'd0) begin
      bad++;
      $display("FAIL reset_mid got digits=%h err=%b st=%0d exp all zero", digits, digit_err, fsm_state);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fv0 = fv_seen;
    stable(3, pat[4]);
    total++;
    if (fv_seen != fv0 || digits !== 16'h4000) begin
      bad++;
      $display("FAIL reset_mid_frame got fv=%0d digits=%h exp 0 and 4000", fv_seen - fv0, digits);
    end
  endtask

  task automatic test_random();
    logic [3:0] an = 4'b0001;
    logic [6:0] sg = 7'h3F;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) >= 50) begin
        if ($urandom_range(0, 99) < 80) an = 4'(1 << $urandom_range(0, 3));
        else an = 4'($urandom);
        if ($urandom_range(0, 99) < 85) sg = pat[$urandom_range(0, 15)];
        else sg = 7'($urandom);
      end
      strobe(an, sg, (i == 399) ? 1 : int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_digit_err();
    test_anode_err();
    test_bad_order();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
